// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit (mem_stage_lsu).
// Optional MEM_STAGE_MISALIGN_TRAP_EN uses is_misaligned() below.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      SZ_WORD = 2'b00,
      SZ_HALF = 2'b01,
      SZ_BYTE = 2'b10,
      SZ_RSVD = 2'b11
   } mem_size_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } lsu_state_e;

   typedef enum logic [1:0] {
      M2R_ALU = 2'd0,
      M2R_MEM = 2'd1,
      M2R_PCI = 2'd2
   } mem_to_reg_e;

   // Reserved size behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic mis;
      case (mem_size_e'(size))
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = off[0];
         default: mis = (off != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and load extraction/extension.
// MEM_STAGE_MISALIGN_TRAP_EN adds the st_misalign detect output.
module lsu_lane_align
   import mem_stage_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   output logic        st_misalign,
`endif
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_off,
   input  logic        ld_signed,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_f;
   logic [15:0] half_f;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (mem_size_e'(st_size))
         SZ_BYTE: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         SZ_HALF: begin
            st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{st_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      endcase
   end

   // Half and word ignore the low offset bits, so misaligned accesses force-align.
   always_comb begin
      byte_f  = ld_rdata[{ld_off, 3'b000} +: 8];
      half_f  = ld_rdata[{ld_off[1], 4'b0000} +: 16];
      ld_data = ld_rdata;
      case (mem_size_e'(ld_size))
         SZ_BYTE: ld_data = {{24{ld_signed & byte_f[7]}}, byte_f};
         SZ_HALF: ld_data = {{16{ld_signed & half_f[15]}}, half_f};
         default: ld_data = ld_rdata;
      endcase
   end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign st_misalign = is_misaligned(st_size, st_off);
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: data-memory req/ack load/store and MEM/WB register.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Valid,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [1:0]        MemSize,
   input  logic              MemSigned,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [31:0]       PCI,
   input  logic [1:0]        MemToReg,
   input  logic              RegWrite,
   input  logic [4:0]        WriteReg,
   output logic              DMemReq,
   output logic              DMemWe,
   output logic [ADDR_W-1:0] DMemAddr,
   output logic [DATA_W-1:0] DMemWData,
   output logic [3:0]        DMemBe,
   input  logic [DATA_W-1:0] DMemRData,
   input  logic              DMemAck,
   output logic              MemStall,
   output logic              WB_Valid,
   output logic              WB_RegWrite,
   output logic [4:0]        WB_WriteReg,
   output logic [1:0]        WB_MemToReg,
   output logic [DATA_W-1:0] WB_ALUResult,
   output logic [DATA_W-1:0] WB_ReadData,
   output logic [31:0]       WB_PCI,
   output logic              MisalignExc
);

   lsu_state_e state, state_n;

   logic              mem_op;
   logic              trap;
   logic              start;
   logic              wb_ld;
   logic              wb_valid_n;
   logic              exc_n;
   logic [DATA_W-1:0] rdata_n;

   logic [3:0]        st_be;
   logic [31:0]       st_wdata;
   logic [31:0]       ld_data;

   logic [ADDR_W-1:2] lat_addr;
   logic [1:0]        lat_off;
   logic [1:0]        lat_size;
   logic              lat_signed;
   logic              lat_we;
   logic [3:0]        lat_be;
   logic [DATA_W-1:0] lat_wdata;

   assign mem_op = Valid & (MemRead | MemWrite);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic misalign;
   assign trap = mem_op & misalign;
`else
   assign trap = 1'b0;
`endif

   lsu_lane_align u_lane (
      .st_size     (MemSize),
      .st_off      (ALUResult[1:0]),
      .st_data     (WriteData),
      .st_be       (st_be),
      .st_wdata    (st_wdata),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      .st_misalign (misalign),
`endif
      .ld_size     (lat_size),
      .ld_off      (lat_off),
      .ld_signed   (lat_signed),
      .ld_rdata    (DMemRData),
      .ld_data     (ld_data)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n    = state;
      MemStall   = 1'b0;
      start      = 1'b0;
      wb_ld      = 1'b0;
      wb_valid_n = 1'b0;
      exc_n      = 1'b0;
      rdata_n    = '0;
      case (state)
         ST_IDLE: begin
            if (mem_op && !trap) begin
               start    = 1'b1;
               MemStall = 1'b1;
               state_n  = ST_BUSY;
            end else begin
               wb_ld      = 1'b1;
               wb_valid_n = Valid;
               exc_n      = trap;
            end
         end
         ST_BUSY: begin
            if (DMemAck) begin
               wb_ld      = 1'b1;
               wb_valid_n = 1'b1;
               rdata_n    = lat_we ? '0 : ld_data;
               state_n    = ST_IDLE;
            end else begin
               MemStall = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Pass-through fields are still held upstream on the ack cycle, so they load then.
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         WB_Valid     <= 1'b0;
         WB_RegWrite  <= 1'b0;
         WB_WriteReg  <= '0;
         WB_MemToReg  <= '0;
         WB_ALUResult <= '0;
         WB_ReadData  <= '0;
         WB_PCI       <= '0;
         MisalignExc  <= 1'b0;
         lat_addr     <= '0;
         lat_off      <= '0;
         lat_size     <= '0;
         lat_signed   <= 1'b0;
         lat_we       <= 1'b0;
         lat_be       <= '0;
         lat_wdata    <= '0;
      end else begin
         WB_Valid    <= wb_valid_n;
         MisalignExc <= exc_n;
         if (wb_ld) begin
            WB_RegWrite  <= RegWrite & ~exc_n;
            WB_WriteReg  <= WriteReg;
            WB_MemToReg  <= MemToReg;
            WB_ALUResult <= ALUResult;
            WB_ReadData  <= rdata_n;
            WB_PCI       <= PCI;
         end
         if (start) begin
            lat_addr   <= ALUResult[ADDR_W-1:2];
            lat_off    <= ALUResult[1:0];
            lat_size   <= MemSize;
            lat_signed <= MemSigned;
            lat_we     <= MemWrite;
            lat_be     <= st_be;
            lat_wdata  <= st_wdata;
         end
      end
   end

   assign DMemReq   = (state == ST_BUSY);
   assign DMemWe    = DMemReq & lat_we;
   assign DMemAddr  = {lat_addr, 2'b00};
   assign DMemBe    = DMemReq ? lat_be : 4'b0000;
   assign DMemWData = lat_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu; honours MEM_STAGE_MISALIGN_TRAP_EN when defined.
`timescale 1ns/1ps
module tb_mem_stage_lsu;
   import mem_stage_pkg::*;

   logic        Clock, Reset, Valid, MemRead, MemWrite, MemSigned, RegWrite, DMemAck;
   logic        DMemReq, DMemWe, MemStall, WB_Valid, WB_RegWrite, MisalignExc;
   logic [1:0]  MemSize, MemToReg, WB_MemToReg;
   logic [4:0]  WriteReg, WB_WriteReg;
   logic [3:0]  DMemBe;
   logic [31:0] ALUResult, WriteData, PCI, DMemAddr, DMemWData, DMemRData;
   logic [31:0] WB_ALUResult, WB_ReadData, WB_PCI;

   int unsigned errors = 0;
   int unsigned checks = 0;

   mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .Clock(Clock), .Reset(Reset), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemSize(MemSize), .MemSigned(MemSigned), .ALUResult(ALUResult), .WriteData(WriteData),
      .PCI(PCI), .MemToReg(MemToReg), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .DMemReq(DMemReq), .DMemWe(DMemWe), .DMemAddr(DMemAddr), .DMemWData(DMemWData),
      .DMemBe(DMemBe), .DMemRData(DMemRData), .DMemAck(DMemAck), .MemStall(MemStall),
      .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg),
      .WB_MemToReg(WB_MemToReg), .WB_ALUResult(WB_ALUResult), .WB_ReadData(WB_ReadData),
      .WB_PCI(WB_PCI), .MisalignExc(MisalignExc)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time %0t reached, required finish before 2000000", $time);
      $fatal(1, "watchdog");
   end

   // Reference model: lane rules expressed as shifts, masks and multiplies.
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [1:0] size, input bit sgn);
      logic [31:0] v;
      if (size == SZ_BYTE) begin
         v = (rdata >> (8 * off)) & 32'hFF;
         if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (size == SZ_HALF) begin
         v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
         if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] off, input logic [1:0] size);
      int unsigned b;
      if (size == SZ_BYTE)      b = 1 << off;
      else if (size == SZ_HALF) b = 3 << (2 * (off / 2));
      else                      b = 15;
      return 4'(b);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] size);
      if (size == SZ_BYTE)      return (wd & 32'hFF) * 32'h0101_0101;
      else if (size == SZ_HALF) return (wd & 32'hFFFF) * 32'h0001_0001;
      else                      return wd;
   endfunction

   function automatic bit ref_trap(input logic [1:0] off, input logic [1:0] size);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      if (size == SZ_BYTE)      return 1'b0;
      else if (size == SZ_HALF) return (off % 2) != 0;
      else                      return off != 0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input bit v, input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pci,
                        input logic [1:0] m2r, input bit rw, input logic [4:0] wreg);
      Valid = v; MemRead = rd; MemWrite = wr; MemSize = sz; MemSigned = sg;
      ALUResult = alu; WriteData = wd; PCI = pci; MemToReg = m2r; RegWrite = rw; WriteReg = wreg;
   endtask

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      drive(1, 1, 0, SZ_WORD, 0, $urandom, $urandom, $urandom, 2'd1, 1, 5'd3);
      tick; tick;
      checks++;
      if ({WB_Valid, WB_RegWrite, WB_WriteReg, WB_MemToReg, WB_ALUResult, WB_ReadData, WB_PCI, MisalignExc} !== '0) begin
         errors++;
         $display("FAIL reset_wb: got %h required 0", {WB_Valid, WB_RegWrite, WB_WriteReg, WB_MemToReg, WB_ALUResult, WB_ReadData, WB_PCI, MisalignExc});
      end
      checks++;
      if ({DMemReq, DMemWe, DMemBe} !== 6'b0) begin
         errors++; $display("FAIL reset_dmem: got %b required 000000", {DMemReq, DMemWe, DMemBe});
      end
      // Reset while an access is outstanding.
      Reset = 1'b1;
      drive(1, 1, 0, SZ_WORD, 0, 32'h40, 0, 32'h48, 2'd1, 1, 5'd4);
      tick;
      checks++;
      if (DMemReq !== 1'b1) begin errors++; $display("FAIL midreset_req: got %b required 1", DMemReq); end
      Reset = 1'b0;
      tick;
      Reset = 1'b1;
      drive(0, 0, 0, SZ_WORD, 0, 0, 0, 0, 2'd0, 0, 5'd0);
      checks++;
      if ({DMemReq, WB_Valid, WB_RegWrite, WB_ALUResult, WB_PCI, WB_ReadData} !== '0) begin
         errors++;
         $display("FAIL midreset_clear: got %h required 0", {DMemReq, WB_Valid, WB_RegWrite, WB_ALUResult, WB_PCI, WB_ReadData});
      end
      tick; tick;
      DMemAck = 1'b1; DMemRData = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({MemStall, DMemReq} !== 2'b00) begin errors++; $display("FAIL stray_ack_comb: got %b required 00", {MemStall, DMemReq}); end
      tick;
      DMemAck = 1'b0;
      checks++;
      if ({WB_Valid, WB_ReadData, DMemReq} !== '0) begin
         errors++; $display("FAIL stray_ack_wb: got %h required 0", {WB_Valid, WB_ReadData, DMemReq});
      end
   endtask

   task automatic test_nonmem;
      drive(1, 0, 0, SZ_WORD, 0, 32'h1234, 32'h55, 32'h100, 2'd0, 1, 5'd5);
      #1;
      checks++;
      if (MemStall !== 1'b0) begin errors++; $display("FAIL nonmem_stall: got %b required 0", MemStall); end
      tick;
      checks++;
      if ({WB_Valid, WB_RegWrite, WB_WriteReg, WB_MemToReg, WB_ALUResult, WB_PCI, WB_ReadData} !==
          {1'b1, 1'b1, 5'd5, 2'd0, 32'h1234, 32'h100, 32'h0}) begin
         errors++;
         $display("FAIL nonmem_wb: got %h required %h", {WB_Valid, WB_RegWrite, WB_WriteReg, WB_MemToReg, WB_ALUResult, WB_PCI, WB_ReadData},
                  {1'b1, 1'b1, 5'd5, 2'd0, 32'h1234, 32'h100, 32'h0});
      end
   endtask

   task automatic test_lb;
      int unsigned stalls;
      logic [31:0] exp;
      for (int s = 1; s >= 0; s--) begin
         exp = (s == 1) ? 32'hFFFF_FF80 : 32'h0000_0080;
         drive(1, 1, 0, SZ_BYTE, s[0], 32'h1003, 0, 32'h500, 2'd1, 1, 5'd8);
         stalls = 0;
         #1 if (MemStall === 1'b1) stalls++;
         tick;
         for (int w = 0; w < 3; w++) begin
            #1 if (MemStall === 1'b1) stalls++;
            tick;
         end
         DMemAck = 1'b1; DMemRData = 32'h80FF_FFFF;
         #1 if (MemStall === 1'b1) stalls++;
         checks++;
         if ({DMemReq, DMemWe, DMemAddr} !== {1'b1, 1'b0, 32'h1000}) begin
            errors++; $display("FAIL lb_req: got %h required %h", {DMemReq, DMemWe, DMemAddr}, {1'b1, 1'b0, 32'h1000});
         end
         tick;
         DMemAck = 1'b0;
         drive(0, 0, 0, SZ_WORD, 0, 0, 0, 0, 2'd0, 0, 5'd0);
         checks++;
         if (stalls != 4) begin errors++; $display("FAIL lb_stall_cycles: got %0d required 4", stalls); end
         checks++;
         if ({WB_Valid, WB_ReadData} !== {1'b1, exp}) begin
            errors++; $display("FAIL lb_data(signed=%0d): got %h required %h", s, {WB_Valid, WB_ReadData}, {1'b1, exp});
         end
      end
   endtask

   task automatic test_sh;
      drive(1, 0, 1, SZ_HALF, 0, 32'h2002, 32'hAAAA_BEEF, 32'h600, 2'd0, 0, 5'd0);
      #1;
      checks++;
      if (MemStall !== 1'b1) begin errors++; $display("FAIL sh_stall: got %b required 1", MemStall); end
      tick;
      #1;
      checks++;
      if ({DMemReq, DMemWe, DMemBe, DMemAddr, DMemWData} !== {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hBEEF_BEEF}) begin
         errors++;
         $display("FAIL sh_req: got %h required %h", {DMemReq, DMemWe, DMemBe, DMemAddr, DMemWData},
                  {1'b1, 1'b1, 4'b1100, 32'h2000, 32'hBEEF_BEEF});
      end
      DMemAck = 1'b1; DMemRData = 32'h1234_5678;
      tick;
      DMemAck = 1'b0;
      checks++;
      if ({WB_Valid, WB_ReadData} !== {1'b1, 32'h0}) begin
         errors++; $display("FAIL sh_wb: got %h required %h", {WB_Valid, WB_ReadData}, {1'b1, 32'h0});
      end
   endtask

   task automatic test_back_to_back;
      drive(1, 1, 0, SZ_WORD, 0, 32'h44, 0, 32'h700, 2'd1, 1, 5'd9);
      tick;
      checks++;
      if (WB_Valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b required 0", WB_Valid); end
      DMemAck = 1'b1; DMemRData = 32'hCAFE_F00D;
      #1;
      checks++;
      if ({DMemReq, MemStall} !== 2'b10) begin errors++; $display("FAIL b2b_ack_cycle: got %b required 10", {DMemReq, MemStall}); end
      tick;
      DMemAck = 1'b0;
      checks++;
      if ({WB_Valid, WB_ReadData, WB_ALUResult, WB_WriteReg} !== {1'b1, 32'hCAFE_F00D, 32'h44, 5'd9}) begin
         errors++;
         $display("FAIL b2b_lw_wb: got %h required %h", {WB_Valid, WB_ReadData, WB_ALUResult, WB_WriteReg}, {1'b1, 32'hCAFE_F00D, 32'h44, 5'd9});
      end
      drive(1, 0, 0, SZ_WORD, 0, 32'h777, 0, 32'h704, 2'd0, 1, 5'd10);
      #1;
      checks++;
      if (MemStall !== 1'b0) begin errors++; $display("FAIL b2b_add_stall: got %b required 0", MemStall); end
      tick;
      checks++;
      if ({WB_Valid, WB_ReadData, WB_ALUResult, WB_WriteReg} !== {1'b1, 32'h0, 32'h777, 5'd10}) begin
         errors++;
         $display("FAIL b2b_add_wb: got %h required %h", {WB_Valid, WB_ReadData, WB_ALUResult, WB_WriteReg}, {1'b1, 32'h0, 32'h777, 5'd10});
      end
   endtask

   task automatic test_misalign;
      drive(1, 1, 0, SZ_WORD, 0, 32'h3001, 0, 32'h800, 2'd1, 1, 5'd11);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      #1;
      checks++;
      if ({MemStall, DMemReq} !== 2'b00) begin errors++; $display("FAIL mis_noreq: got %b required 00", {MemStall, DMemReq}); end
      tick;
      drive(0, 0, 0, SZ_WORD, 0, 0, 0, 0, 2'd0, 0, 5'd0);
      checks++;
      if ({MisalignExc, WB_Valid, WB_RegWrite, WB_ALUResult, DMemReq} !== {1'b1, 1'b1, 1'b0, 32'h3001, 1'b0}) begin
         errors++;
         $display("FAIL mis_trap: got %h required %h", {MisalignExc, WB_Valid, WB_RegWrite, WB_ALUResult, DMemReq}, {1'b1, 1'b1, 1'b0, 32'h3001, 1'b0});
      end
      tick;
      checks++;
      if (MisalignExc !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b required 0", MisalignExc); end
`else
      tick;
      #1;
      checks++;
      if ({DMemReq, DMemBe, DMemAddr} !== {1'b1, 4'b1111, 32'h3000}) begin
         errors++; $display("FAIL mis_align: got %h required %h", {DMemReq, DMemBe, DMemAddr}, {1'b1, 4'b1111, 32'h3000});
      end
      DMemAck = 1'b1; DMemRData = 32'h0BAD_F00D;
      tick;
      DMemAck = 1'b0;
      checks++;
      if ({WB_Valid, WB_ReadData, MisalignExc} !== {1'b1, 32'h0BAD_F00D, 1'b0}) begin
         errors++; $display("FAIL mis_wb: got %h required %h", {WB_Valid, WB_ReadData, MisalignExc}, {1'b1, 32'h0BAD_F00D, 1'b0});
      end
`endif
   endtask

   task automatic test_random;
      bit v, rd, wr, sg, rw, is_mem, trap;
      logic [1:0]  sz, m2r, off;
      logic [4:0]  wreg;
      logic [31:0] alu, wd, pci, rdata, exp_rd;
      int unsigned kind, delay;
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 2);
         v  = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
         rd = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         wr = (kind == 2) ? 1'b1 : ((kind == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
         if (kind == 0 && v) begin rd = 1'b0; wr = 1'b0; end
         sz = 2'($urandom_range(0, 3)); sg = 1'($urandom_range(0, 1));
         alu = $urandom; wd = $urandom; pci = $urandom; rdata = $urandom;
         m2r = 2'($urandom_range(0, 2)); rw = 1'($urandom_range(0, 1)); wreg = 5'($urandom_range(0, 31));
         off = alu[1:0];
         is_mem = v && (rd || wr);
         trap = is_mem && ref_trap(off, sz);
         drive(v, rd, wr, sz, sg, alu, wd, pci, m2r, rw, wreg);
         if (!is_mem || trap) begin
            DMemAck = 1'($urandom_range(0, 1)); DMemRData = rdata;
            #1;
            checks++;
            if ({MemStall, DMemReq} !== 2'b00) begin errors++; $display("FAIL rnd_pass_comb[%0d]: got %b required 00", n, {MemStall, DMemReq}); end
            tick;
            DMemAck = 1'b0;
            exp_rd = 32'h0;
         end else begin
            #1;
            checks++;
            if (MemStall !== 1'b1) begin errors++; $display("FAIL rnd_issue_stall[%0d]: got %b required 1", n, MemStall); end
            tick;
            delay = $urandom_range(0, 3);
            for (int w = 0; w <= int'(delay); w++) begin
               if (w == int'(delay)) begin DMemAck = 1'b1; DMemRData = rdata; end
               #1;
               checks++;
               if ({DMemReq, DMemWe, DMemAddr, DMemBe, MemStall} !== {1'b1, wr, alu & 32'hFFFF_FFFC, ref_be(off, sz), 1'(w != int'(delay))}) begin
                  errors++;
                  $display("FAIL rnd_req[%0d]: got %h required %h", n, {DMemReq, DMemWe, DMemAddr, DMemBe, MemStall},
                           {1'b1, wr, alu & 32'hFFFF_FFFC, ref_be(off, sz), 1'(w != int'(delay))});
               end
               if (wr) begin
                  checks++;
                  if (DMemWData !== ref_wdata(wd, sz)) begin
                     errors++; $display("FAIL rnd_wdata[%0d]: got %h required %h", n, DMemWData, ref_wdata(wd, sz));
                  end
               end
               tick;
               if (w != int'(delay)) begin
                  checks++;
                  if (WB_Valid !== 1'b0) begin errors++; $display("FAIL rnd_bubble[%0d]: got %b required 0", n, WB_Valid); end
               end
            end
            DMemAck = 1'b0;
            exp_rd = wr ? 32'h0 : ref_load(rdata, off, sz, sg);
         end
         checks++;
         if ({WB_Valid, WB_RegWrite, WB_WriteReg, WB_MemToReg, WB_ALUResult, WB_PCI, WB_ReadData, MisalignExc} !==
             {v, rw & ~trap, wreg, m2r, alu, pci, exp_rd, trap}) begin
            errors++;
            $display("FAIL rnd_wb[%0d]: got %h required %h", n,
                     {WB_Valid, WB_RegWrite, WB_WriteReg, WB_MemToReg, WB_ALUResult, WB_PCI, WB_ReadData, MisalignExc},
                     {v, rw & ~trap, wreg, m2r, alu, pci, exp_rd, trap});
         end
      end
   endtask

   initial begin
      Reset = 1'b0; DMemAck = 1'b0; DMemRData = '0;
      drive(0, 0, 0, SZ_WORD, 0, 0, 0, 0, 2'd0, 0, 5'd0);
      #1;
      test_reset;
      test_nonmem;
      test_lb;
      test_sh;
      test_back_to_back;
      test_misalign;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
